// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - byte-level START/bit/ACK/STOP sequencer for i2c_master_phy
// Optional per-command watchdog is enabled by defining I2C_MASTER_CTRL_TIMEOUT_EN.
module i2c_master_ctrl #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_start_i,
    input  logic       req_stop_i,
    input  logic       req_read_i,
    input  logic       req_nack_i,
    input  logic [7:0] req_data_i,
    output logic       resp_valid_o,
    output logic [7:0] resp_data_o,
    output logic       resp_ack_o,
    output logic [1:0] resp_status_o,
    output logic       owns_bus_o,
    output logic [2:0] phy_cmd_o,
    output logic       phy_data_o,
    input  logic       phy_data_i,
    input  logic       phy_cmd_done_i,
    input  logic       phy_arb_lost_i,
    input  logic       phy_bus_busy_i
);

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_STOP  = 3'd2;
    localparam logic [2:0] CMD_WRITE = 3'd3;
    localparam logic [2:0] CMD_READ  = 3'd4;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ARB     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_BUS, S_START, S_TX_BIT, S_RX_BIT,
        S_RX_ACK, S_TX_ACK, S_STOP, S_ABORT, S_RESP
    } state_t;

    state_t      state, next_state;
    logic        lat_stop, lat_read, lat_nack;
    logic [7:0]  lat_data;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_data;
    logic        ack_bit;
    logic [1:0]  status;
    logic        cmd_state, bit_state, arb_hit, timeout_hit;
    logic        accept, illegal, ack_next, entering_resp;
    logic [1:0]  status_next;

    assign cmd_state = (state == S_START) || (state == S_TX_BIT) || (state == S_RX_BIT) ||
                       (state == S_RX_ACK) || (state == S_TX_ACK) || (state == S_STOP);
    assign bit_state = (state == S_TX_BIT) || (state == S_RX_BIT);
    assign arb_hit   = cmd_state && phy_arb_lost_i;
    assign accept    = (state == S_IDLE) && req_valid_i;
    assign illegal   = accept && !req_start_i && !owns_bus_o;

`ifdef I2C_MASTER_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Restarts whenever a new command is presented, i.e. on any state change or done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if ((state != next_state) || phy_cmd_done_i) begin
            to_cnt <= '0;
        end else if (cmd_state || (state == S_ABORT)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (cmd_state || (state == S_ABORT)) && !phy_cmd_done_i &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (illegal)                                          next_state = S_RESP;
                    else if (req_start_i && !owns_bus_o && phy_bus_busy_i) next_state = S_WAIT_BUS;
                    else if (req_start_i)                                  next_state = S_START;
                    else if (req_read_i)                                   next_state = S_RX_BIT;
                    else                                                   next_state = S_TX_BIT;
                end
            end
            S_WAIT_BUS: if (!phy_bus_busy_i) next_state = S_START;
            S_START:    if (phy_cmd_done_i) next_state = lat_read ? S_RX_BIT : S_TX_BIT;
            S_TX_BIT:   if (phy_cmd_done_i && bit_cnt == 3'd0) next_state = S_RX_ACK;
            S_RX_BIT:   if (phy_cmd_done_i && bit_cnt == 3'd0) next_state = S_TX_ACK;
            S_RX_ACK,
            S_TX_ACK:   if (phy_cmd_done_i) next_state = lat_stop ? S_STOP : S_RESP;
            S_STOP:     if (phy_cmd_done_i) next_state = S_RESP;
            S_ABORT:    if (phy_cmd_done_i) next_state = S_RESP;
            S_RESP:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
        // Losing arbitration outranks a coincident done and the watchdog.
        if (arb_hit)          next_state = phy_cmd_done_i ? S_RESP : S_ABORT;
        else if (timeout_hit) next_state = S_RESP;
    end

    always_comb begin
        req_ready_o  = (state == S_IDLE);
        resp_valid_o = (state == S_RESP);
        phy_cmd_o    = CMD_NOP;
        phy_data_o   = 1'b1;
        case (state)
            S_START:  phy_cmd_o = CMD_START;
            S_TX_BIT: begin
                phy_cmd_o  = CMD_WRITE;
                phy_data_o = lat_data[bit_cnt];
            end
            S_TX_ACK: begin
                phy_cmd_o  = CMD_WRITE;
                phy_data_o = lat_nack;
            end
            S_RX_BIT, S_RX_ACK: phy_cmd_o = CMD_READ;
            S_STOP:   phy_cmd_o = CMD_STOP;
            default:  phy_cmd_o = CMD_NOP;
        endcase
    end

    assign ack_next      = (state == S_RX_ACK && phy_cmd_done_i && !arb_hit) ? ~phy_data_i : ack_bit;
    assign status_next   = arb_hit ? ST_ARB : (timeout_hit ? ST_TIMEOUT : status);
    assign entering_resp = (next_state == S_RESP) && (state != S_RESP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_stop      <= 1'b0;
            lat_read      <= 1'b0;
            lat_nack      <= 1'b0;
            lat_data      <= 8'h00;
            bit_cnt       <= 3'd7;
            rx_data       <= 8'h00;
            ack_bit       <= 1'b0;
            status        <= ST_OK;
            owns_bus_o    <= 1'b0;
            resp_data_o   <= 8'h00;
            resp_ack_o    <= 1'b0;
            resp_status_o <= ST_OK;
        end else begin
            if (accept) begin
                lat_stop <= req_stop_i;
                lat_read <= req_read_i;
                lat_nack <= req_nack_i;
                lat_data <= req_data_i;
                rx_data  <= 8'h00;
                ack_bit  <= 1'b0;
                status   <= ST_OK;
            end
            if (bit_state) begin
                if (phy_cmd_done_i) bit_cnt <= bit_cnt - 3'd1;
            end else begin
                bit_cnt <= 3'd7;
            end
            if (state == S_RX_BIT && phy_cmd_done_i && !arb_hit) rx_data[bit_cnt] <= phy_data_i;
            ack_bit <= ack_next;
            if (cmd_state || state == S_ABORT) status <= status_next;

            if (arb_hit || timeout_hit)                               owns_bus_o <= 1'b0;
            else if (state == S_START && phy_cmd_done_i)              owns_bus_o <= 1'b1;
            else if (state == S_STOP && phy_cmd_done_i)               owns_bus_o <= 1'b0;

            if (entering_resp) begin
                if (state == S_IDLE) begin
                    resp_data_o   <= 8'h00;
                    resp_ack_o    <= 1'b0;
                    resp_status_o <= ST_ILLEGAL;
                end else begin
                    resp_data_o   <= lat_read ? rx_data : 8'h00;
                    resp_ack_o    <= !lat_read && ack_next;
                    resp_status_o <= status_next;
                end
            end
        end
    end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Byte-level sequencer for `i2c_master_phy`: accepts one byte transaction per request and issues the START / WRITE / READ / STOP bit commands to the PHY in order. For each byte it handles START (including repeated START), 8 data bits MSB first, the ACK bit and an optional STOP. It reports read data, slave ACK and a status code. It sits between a register / host front end and the PHY, and owns the PHY command port exclusively.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: watchdog limit in clk_i cycles per PHY command. Used only with `I2C_MASTER_CTRL_TIMEOUT_EN`.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high. Clock is `clk_i`.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `req_start_i` in 1: issue START or repeated START before the byte.
- `req_stop_i` in 1: issue STOP after the ACK bit.
- `req_read_i` in 1: 1 = read byte, 0 = write byte.
- `req_nack_i` in 1: for reads, ACK bit value driven by the master (1 = NACK).
- `req_data_i` in 8: write byte.
- `resp_valid_o` out 1: single-cycle completion pulse.
- `resp_data_o` out 8: read byte (0 for writes).
- `resp_ack_o` out 1: write only, 1 = slave pulled SDA low on the ACK bit.
- `resp_status_o` out 2: 0 OK, 1 ARB_LOST, 2 TIMEOUT, 3 ILLEGAL.
- `owns_bus_o` out 1: high from completion of own START to completion of own STOP.
- `phy_cmd_o` out 3: i2c_pkg START / STOP / READ / WRITE, or NOP when idle.
- `phy_data_o` out 1: bit to write.
- `phy_data_i` in 1: bit read, valid at `phy_cmd_done_i`.
- `phy_cmd_done_i`, `phy_arb_lost_i`, `phy_bus_busy_i` in 1: PHY status.

## Operation
- **States:** IDLE, WAIT_BUS, START, TX_BIT, RX_BIT, RX_ACK, TX_ACK, STOP, ABORT, RESP.
- **IDLE:** `req_ready_o`=1; other states 0. On accept, all `req_*` fields are latched.
- **Start without bus:** start=1, `owns_bus_o`=0, `phy_bus_busy_i`=1 → WAIT_BUS until busy=0, then START.
- **No start, no bus:** start=0 while `owns_bus_o`=0 → RESP with ILLEGAL. No PHY command is issued.
- **START done:** `owns_bus_o`←1. Next state is TX_BIT (write) or RX_BIT (read).
- **Bit counter:** 3-bit, loaded with 7, decremented on each done; exits after bit 0.
- **TX_BIT:** `phy_data_o` = `req_data[cnt]`.
- **RX_BIT:** `resp_data_o[cnt]` ← `phy_data_i` at done.
- **Write ACK:** after a write byte → RX_ACK (READ command); `resp_ack_o` ← !`phy_data_i`.
- **Read ACK:** after a read byte → TX_ACK (WRITE command, data = `req_nack_i`).
- **After ACK:** → STOP if stop=1, else RESP.
- **STOP done:** `owns_bus_o`←0, then → RESP.
- **Arbitration lost:** `phy_arb_lost_i` in any command state → ABORT. `phy_cmd_o`=NOP, `phy_data_o`=1. Wait for done of the in-flight command, then RESP with ARB_LOST and `owns_bus_o`←0. No STOP is issued.
- **Simultaneous arb_lost and done:** arb_lost wins; go directly to RESP with ARB_LOST.
- **RESP:** one cycle, then back to IDLE.

## Timing
- **Reset values:** `req_ready_o`=1, `resp_valid_o`=0, `resp_data_o`=0, `resp_ack_o`=0, `resp_status_o`=0, `owns_bus_o`=0, `phy_cmd_o`=NOP, `phy_data_o`=1. All are registered.
- **First command:** `phy_cmd_o` carries the first command on the cycle after accept (or after busy clears).
- **Command hold:** `phy_cmd_o` and `phy_data_o` are held stable until `phy_cmd_done_i`=1.
- **Command update:** the next command (or NOP after the last) is registered on the same edge that samples done. There is no NOP gap between commands.
- **Response:** `resp_valid_o` pulses the cycle after the final done. `resp_*` fields hold until the next response.
- **Earliest next accept:** the cycle after the `resp_valid_o` pulse.
- **Latency:** write byte with START+STOP = 11 PHY commands (START, 8 bits, ACK, STOP). Without either, 9 commands.
- **Reset mid-transaction:** all outputs return immediately to reset values. The PHY is reset by the same `rst_i`.

## Configuration
- **`I2C_MASTER_CTRL_TIMEOUT_EN` defined:**
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter clears when each command is issued and increments while waiting for done.
  - At `TIMEOUT_CYCLES` without done: `phy_cmd_o`=NOP, `owns_bus_o`←0, then RESP with TIMEOUT.
- **Undefined:** no counter; the block waits for done indefinitely and status 2 is never produced.

## Test plan
- **Write with START+STOP:** write 0xA5, slave ACKs → commands START, W1,0,1,0,0,1,0,1, READ, STOP. Response: ack=1, status 0. `owns_bus_o` rises after START and falls after STOP.
- **Read with repeated START, no STOP:** read with nack=1, slave drives 0x3C → `resp_data_o`=0x3C, ACK command is WRITE with data 1, `owns_bus_o` stays 1. A following start=1 request issues START with no WAIT_BUS.
- **Bus busy:** `phy_bus_busy_i`=1 and start=1 with no ownership → no command while busy. START is issued the cycle after busy falls.
- **Arbitration lost:** `phy_arb_lost_i` during bit 5 of a write → NOP after the in-flight done, status 1, `owns_bus_o`=0, no STOP.
- **Illegal request and timeout:** start=0 with no ownership → status 3, zero commands. With the macro defined and `TIMEOUT_CYCLES`=50, done is withheld → status 2 after exactly 50 cycles.
